// File: rtl/popcnt_pkg.sv
// Shared definitions for the popcount frame path: widths, FSM states and the
// one-hot to binary conversion used by every consumer of the counter stage.
package popcnt_pkg;

    localparam int ONEHOT_W = 13;
    localparam int COUNT_W  = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Returns {bad, count}; zero or multiple set bits give bad = 1 and count = 0.
    function automatic logic [COUNT_W:0] onehot_to_bin(input logic [ONEHOT_W-1:0] onehot);
        logic [COUNT_W-1:0] idx;
        logic [COUNT_W-1:0] ones;
        logic               bad;
        idx  = '0;
        ones = '0;
        for (int k = 0; k < ONEHOT_W; k++) begin
            if (onehot[k]) begin
                idx  = COUNT_W'(k);
                ones = ones + COUNT_W'(1);
            end
        end
        bad = (ones != COUNT_W'(1));
        return {bad, (bad ? COUNT_W'(0) : idx)};
    endfunction

endpackage

// File: rtl/onehot_dec13.sv
// Combinational 13-bit one-hot to binary decoder with a malformed-input flag.
module onehot_dec13
    import popcnt_pkg::*;
(
    input  logic [ONEHOT_W-1:0] onehot_i,
    output logic [COUNT_W-1:0]  count_o,
    output logic                bad_o
);

    logic [COUNT_W:0] dec;

    always_comb begin
        dec = onehot_to_bin(onehot_i);
    end

    assign bad_o   = dec[COUNT_W];
    assign count_o = dec[COUNT_W-1:0];

endmodule

// File: rtl/popcnt_accum.sv
// Frame accumulator behind the one-hot popcount stage: sums FRAME_LEN beats,
// tracks the per-frame maximum and error sticky, and holds each frame result.
module popcnt_accum
    import popcnt_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [12:0]      in_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [3:0]       out_max,
    output logic             out_err,
    output logic             dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and out_* hold while valid & !ready.

    localparam int                BEAT_W    = 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    state_t             state_q;
    logic [BEAT_W-1:0]  beat_cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [COUNT_W-1:0] max_q;
    logic [COUNT_W-1:0] max_d;
    logic               err_q;
    logic               err_d;
    logic               out_valid_q;
    logic [ACC_W-1:0]   out_total_q;
    logic [COUNT_W-1:0] out_max_q;
    logic               out_err_q;

    logic [COUNT_W-1:0] beat_count;
    logic               beat_bad;
    logic               accept;
    logic               last_beat;

    onehot_dec13 u_dec (
        .onehot_i (in_onehot),
        .count_o  (beat_count),
        .bad_o    (beat_bad)
    );

    // Ready comes only from registered state, so no out_ready pass-through.
    assign in_ready  = rst_n && (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt_q == LAST_BEAT);

    always_comb begin
        acc_d = acc_q + ACC_W'(beat_count);
        max_d = (beat_count > max_q) ? beat_count : max_q;
        err_d = err_q | beat_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            beat_cnt_q  <= '0;
            acc_q       <= '0;
            max_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_total_q <= '0;
            out_max_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (last_beat) begin
                            out_total_q <= acc_d;
                            out_max_q   <= max_d;
                            out_err_q   <= err_d;
                            out_valid_q <= 1'b1;
                            acc_q       <= '0;
                            max_q       <= '0;
                            err_q       <= 1'b0;
                            beat_cnt_q  <= '0;
                            state_q     <= HOLD;
                        end else begin
                            acc_q      <= acc_d;
                            max_q      <= max_d;
                            err_q      <= err_d;
                            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ACCUM;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_total = out_total_q;
    assign out_max   = out_max_q;
    assign out_err   = out_err_q;
    assign dbg_state = (state_q == HOLD);

endmodule

// File: tb/tb_popcnt_accum.sv
// Bench for popcnt_accum: a FRAME_LEN=16 and a FRAME_LEN=1 instance share one
// stimulus stream; a frame-level reference model checks both every cycle.
module tb_popcnt_accum;

  localparam int ACC_W = 12;
  localparam int RW    = ACC_W + 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [12:0]       in_onehot;
  logic              out_ready;

  logic              in_ready0, out_valid0, out_err0, dbg0;
  logic [ACC_W-1:0]  out_total0;
  logic [3:0]        out_max0;
  logic              in_ready1, out_valid1, out_err1, dbg1;
  logic [ACC_W-1:0]  out_total1;
  logic [3:0]        out_max1;

  int checks   = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk = ~clk;

  popcnt_accum #(.FRAME_LEN(16), .ACC_W(ACC_W)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_onehot(in_onehot), .out_valid(out_valid0), .out_ready(out_ready),
    .out_total(out_total0), .out_max(out_max0), .out_err(out_err0), .dbg_state(dbg0)
  );

  popcnt_accum #(.FRAME_LEN(1), .ACC_W(ACC_W)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_onehot(in_onehot), .out_valid(out_valid1), .out_ready(out_ready),
    .out_total(out_total1), .out_max(out_max1), .out_err(out_err1), .dbg_state(dbg1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: frame-level arithmetic on decoded counts
  int               frame_len [2] = '{16, 1};
  int               m_sum [2];
  int               m_max [2];
  int               m_n   [2];
  bit               m_err [2];
  bit               m_hold[2];
  logic [RW-1:0]    m_last[2];
  bit               m_init = 1'b0;
  logic [RW-1:0]    exp_q0[$];
  logic [RW-1:0]    exp_q1[$];

  task automatic model_step(input int i, input logic rdy, input logic vld,
                            input logic [ACC_W-1:0] tot, input logic [3:0] mx,
                            input logic er);
    logic [RW-1:0] obs;
    logic [RW-1:0] exp_r;
    string         p;
    int            c;
    bit            bad;
    p   = (i == 0) ? "f16" : "f1";
    obs = {er, mx, tot};
    if (m_init) begin
      check({p, ".in_ready"}, 32'(rdy), 32'(rst_n && !m_hold[i]));
      check({p, ".out_valid"}, 32'(vld), 32'(m_hold[i]));
      check({p, ".out_result"}, 32'(obs), 32'(m_last[i]));
    end
    if (!rst_n) begin
      m_sum[i] = 0; m_max[i] = 0; m_n[i] = 0; m_err[i] = 0;
      m_hold[i] = 0; m_last[i] = '0;
      if (i == 0) exp_q0.delete(); else exp_q1.delete();
    end else if (m_hold[i]) begin
      if (out_ready) begin
        if (i == 0 && exp_q0.size() > 0) begin
          exp_r = exp_q0.pop_front();
          check({p, ".handshake"}, 32'(obs), 32'(exp_r));
        end else if (i == 1 && exp_q1.size() > 0) begin
          exp_r = exp_q1.pop_front();
          check({p, ".handshake"}, 32'(obs), 32'(exp_r));
        end else begin
          check({p, ".scoreboard_empty"}, 32'(1), 32'(0));
        end
        m_hold[i] = 0;
      end
    end else if (in_valid) begin
      bad = ($countones(in_onehot) != 1);
      c   = bad ? 0 : $clog2(in_onehot);
      m_sum[i] += c;
      if (c > m_max[i]) m_max[i] = c;
      m_err[i] |= bad;
      m_n[i]++;
      if (m_n[i] == frame_len[i]) begin
        m_last[i] = {m_err[i], 4'(m_max[i]), ACC_W'(m_sum[i])};
        if (i == 0) exp_q0.push_back(m_last[i]); else exp_q1.push_back(m_last[i]);
        m_hold[i] = 1;
        m_sum[i] = 0; m_max[i] = 0; m_n[i] = 0; m_err[i] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, in_ready0, out_valid0, out_total0, out_max0, out_err0);
    model_step(1, in_ready1, out_valid1, out_total1, out_max1, out_err1);
    if (!rst_n) m_init = 1'b1;
  end

  // driver tasks: called at posedge+1, apply inputs for one cycle
  task automatic drive(input logic v, input logic [12:0] oh);
    in_valid  = v;
    in_onehot = oh;
    @(posedge clk); #1;
  endtask

  task automatic expect_frame16(input string tag, input int tot, input int mx, input int er);
    @(negedge clk);
    check({tag, ".valid"}, 32'(out_valid0), 32'(1));
    check({tag, ".total"}, 32'(out_total0), 32'(tot));
    check({tag, ".max"},   32'(out_max0),   32'(mx));
    check({tag, ".err"},   32'(out_err0),   32'(er));
  endtask

  int pulses;
  logic [12:0] oh;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_onehot = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 16 beats of count 6, out_ready high: one-cycle out_valid
    for (int b = 0; b < 16; b++) drive(1'b1, 13'h0040);
    in_valid = 1'b0;
    expect_frame16("t1", 96, 6, 0);
    @(negedge clk);
    check("t1.valid_one_cycle", 32'(out_valid0), 32'(0));
    @(posedge clk); #1;

    // counts 0..12 then 0,1,2
    for (int b = 0; b < 16; b++) begin
      oh = 13'h0001 << (b % 13);
      drive(1'b1, oh);
    end
    in_valid = 1'b0;
    expect_frame16("t2", 81, 12, 0);
    @(posedge clk); #1;

    // two malformed beats among count-1 beats, then a clean frame
    for (int b = 0; b < 16; b++) begin
      if (b == 3)      drive(1'b1, 13'h0000);
      else if (b == 9) drive(1'b1, 13'h0003);
      else             drive(1'b1, 13'h0002);
    end
    in_valid = 1'b0;
    expect_frame16("t3", 14, 1, 1);
    @(posedge clk); #1;
    for (int b = 0; b < 16; b++) drive(1'b1, 13'h0004);
    in_valid = 1'b0;
    expect_frame16("t3_clean", 32, 2, 0);
    @(posedge clk); #1;

    // back-pressure: hold 5 cycles while beats are offered
    out_ready = 1'b0;
    for (int b = 0; b < 16; b++) drive(1'b1, 13'h0008);
    in_onehot = 13'h1000;
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      check("t4.hold_valid", 32'(out_valid0), 32'(1));
      check("t4.hold_ready", 32'(in_ready0),  32'(0));
      check("t4.hold_total", 32'(out_total0), 32'(48));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t4.pre_hs_ready", 32'(in_ready0), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("t4.post_hs_ready", 32'(in_ready0),  32'(1));
    check("t4.post_hs_valid", 32'(out_valid0), 32'(0));
    check("t4.post_hs_total", 32'(out_total0), 32'(48));
    @(posedge clk); #1;

    // reset in mid-frame discards the partial frame
    for (int b = 0; b < 7; b++) drive(1'b1, 13'h0020);
    rst_n = 1'b0;
    drive(1'b1, 13'h0040);
    @(negedge clk);
    check("t5.rst_valid", 32'(out_valid0), 32'(0));
    check("t5.rst_total", 32'(out_total0), 32'(0));
    check("t5.rst_max",   32'(out_max0),   32'(0));
    check("t5.rst_ready", 32'(in_ready0),  32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    for (int b = 0; b < 16; b++) drive(1'b1, 13'h0004);
    in_valid = 1'b0;
    expect_frame16("t5", 32, 2, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // single-beat frames: out_valid every other cycle
    pulses = 0;
    in_valid = 1'b1; in_onehot = 13'h1000;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (out_valid1) begin
        pulses++;
        check("t6.total", 32'(out_total1), 32'(12));
      end
      @(posedge clk); #1;
    end
    check("t6.pulses", 32'(pulses), 32'(10));
    in_valid = 1'b0;

    // randomized traffic
    for (int w = 0; w < 600; w++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) in_onehot = 13'($urandom);
      else                           in_onehot = 13'h0001 << $urandom_range(0, 12);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
